unified_memory_arbiter: RTL and testbench

- Single-owner sequencer for the unified byte-addressable instruction/data memory, which has a combinational little-endian read and a clk-synchronous write.
- Shares the one memory port between the instruction-fetch requester (IF) and the load/store requester (DM).
- Round-robin arbitration on conflict; alignment and size checks; registered read data with a done pulse.
- Sits between the fetch/LSU logic and the memory instance.

---
 rtl/unified_memory_arbiter_if.sv | 48 ++++
 rtl/unified_memory_arbiter.sv | 143 ++++++++++++++
 tb/tb_unified_memory_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_memory_arbiter_if.sv
// Request/response bundle between the fetch/LSU requesters, the arbiter and the unified memory.
// The slave view is the arbiter; the master view is the requester-plus-memory side.
interface unified_memory_arbiter_if #(
  parameter int addr_width = 9
);
  logic                  if_req;
  logic [addr_width-1:0] if_address;
  logic [31:0]           if_read_data;
  logic                  if_done;
  logic                  if_error;

  logic                  dm_req;
  logic                  dm_write_enable;
  logic                  dm_word;
  logic                  dm_half;
  logic                  dm_single_byte;
  logic [addr_width-1:0] dm_address;
  logic [31:0]           dm_write_data;
  logic [31:0]           dm_read_data;
  logic                  dm_done;
  logic                  dm_error;

  logic                  mem_write_enable;
  logic                  mem_word;
  logic                  mem_half;
  logic                  mem_single_byte;
  logic [addr_width-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport slave (
    input  if_req, if_address,
    output if_read_data, if_done, if_error,
    input  dm_req, dm_write_enable, dm_word, dm_half, dm_single_byte, dm_address, dm_write_data,
    output dm_read_data, dm_done, dm_error,
    output mem_write_enable, mem_word, mem_half, mem_single_byte, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output if_req, if_address,
    input  if_read_data, if_done, if_error,
    output dm_req, dm_write_enable, dm_word, dm_half, dm_single_byte, dm_address, dm_write_data,
    input  dm_read_data, dm_done, dm_error,
    input  mem_write_enable, mem_word, mem_half, mem_single_byte, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Single-owner sequencer for the shared instruction/data memory port: round-robin between
// fetch and load/store, alignment/size checking, registered read data and one-cycle done pulses.
module unified_memory_arbiter #(
  parameter int num_thirty_two_bit_words = 128,
  parameter int addr_width = $clog2(num_thirty_two_bit_words * 4)
) (
  input logic                    clk,
  input logic                    reset,
  unified_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;   // 1 = DM held the port last
  logic                  sel_dm_q, sel_dm_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_word_q, mem_word_d;
  logic                  mem_half_q, mem_half_d;
  logic                  mem_byte_q, mem_byte_d;
  logic [addr_width-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  if_done_q, if_done_d;
  logic                  if_error_q, if_error_d;
  logic                  dm_done_q, dm_done_d;
  logic                  dm_error_q, dm_error_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           dm_rdata_q, dm_rdata_d;

  logic pick_dm;
  logic if_illegal;
  logic dm_illegal;

  // On conflict the requester that did not hold the port last wins.
  assign pick_dm    = bus.dm_req && (!bus.if_req || !last_grant_q);
  assign if_illegal = bus.if_address[1:0] != 2'b00;
  assign dm_illegal = !$onehot({bus.dm_word, bus.dm_half, bus.dm_single_byte})
                    || (bus.dm_word && (bus.dm_address[1:0] != 2'b00))
                    || (bus.dm_half && bus.dm_address[0]);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_dm_d     = sel_dm_q;
    mem_we_d     = 1'b0;
    mem_word_d   = 1'b0;
    mem_half_d   = 1'b0;
    mem_byte_d   = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    if_done_d    = 1'b0;
    if_error_d   = 1'b0;
    dm_done_d    = 1'b0;
    dm_error_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          sel_dm_d     = pick_dm;
          last_grant_d = pick_dm;
          if (pick_dm ? dm_illegal : if_illegal) begin
            // Illegal requests skip the memory cycle and report straight away.
            state_d    = RESP;
            if_done_d  = !pick_dm;
            if_error_d = !pick_dm;
            dm_done_d  = pick_dm;
            dm_error_d = pick_dm;
          end else begin
            state_d     = ACCESS;
            mem_we_d    = pick_dm && bus.dm_write_enable;
            mem_word_d  = pick_dm ? bus.dm_word : 1'b1;
            mem_half_d  = pick_dm && bus.dm_half;
            mem_byte_d  = pick_dm && bus.dm_single_byte;
            mem_addr_d  = pick_dm ? bus.dm_address : bus.if_address;
            mem_wdata_d = pick_dm ? bus.dm_write_data : 32'h0;
          end
        end
      end
      ACCESS: begin
        state_d   = RESP;
        if_done_d = !sel_dm_q;
        dm_done_d = sel_dm_q;
        if (!mem_we_q) begin
          if (sel_dm_q) dm_rdata_d = bus.mem_read_data;
          else          if_rdata_d = bus.mem_read_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      sel_dm_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_word_q   <= 1'b0;
      mem_half_q   <= 1'b0;
      mem_byte_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      if_error_q   <= 1'b0;
      dm_done_q    <= 1'b0;
      dm_error_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_dm_q     <= sel_dm_d;
      mem_we_q     <= mem_we_d;
      mem_word_q   <= mem_word_d;
      mem_half_q   <= mem_half_d;
      mem_byte_q   <= mem_byte_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      if_error_q   <= if_error_d;
      dm_done_q    <= dm_done_d;
      dm_error_q   <= dm_error_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_word         = mem_word_q;
  assign bus.mem_half         = mem_half_q;
  assign bus.mem_single_byte  = mem_byte_q;
  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_write_data   = mem_wdata_q;
  assign bus.if_done          = if_done_q;
  assign bus.if_error         = if_error_q;
  assign bus.if_read_data     = if_rdata_q;
  assign bus.dm_done          = dm_done_q;
  assign bus.dm_error         = dm_error_q;
  assign bus.dm_read_data     = dm_rdata_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: directed scenarios with literal expectations, then random
// traffic from both requesters compared every cycle against a timeline model of the arbiter.
module tb_unified_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_memory_arbiter_if #(.addr_width(9)) bus();

  unified_memory_arbiter #(.num_thirty_two_bit_words(128)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Memory environment: combinational little-endian read, clocked write.
  logic [7:0] mem [0:511];
  logic       pl_en;
  logic [8:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_write_enable) begin
      mem[bus.mem_address] <= bus.mem_write_data[7:0];
      if (bus.mem_half || bus.mem_word) mem[bus.mem_address + 9'd1] <= bus.mem_write_data[15:8];
      if (bus.mem_word) begin
        mem[bus.mem_address + 9'd2] <= bus.mem_write_data[23:16];
        mem[bus.mem_address + 9'd3] <= bus.mem_write_data[31:24];
      end
    end
  end

  always_comb begin
    logic [31:0] w;
    w = {mem[bus.mem_address + 9'd3], mem[bus.mem_address + 9'd2],
         mem[bus.mem_address + 9'd1], mem[bus.mem_address]};
    if (bus.mem_single_byte)  bus.mem_read_data = {24'h0, w[7:0]};
    else if (bus.mem_half)    bus.mem_read_data = {16'h0, w[15:0]};
    else                      bus.mem_read_data = w;
  end

  // Reference model: expected outputs for the current cycle and the next one.
  typedef struct packed {
    logic ifd, ife, dmd, dme, acc, who, we, w, h, b;
    logic [8:0]  a;
    logic [31:0] wd;
  } exp_t;

  exp_t        cur, n1;
  int          busy;
  logic        lg;
  logic [31:0] if_rd_m, dm_rd_m;
  logic [7:0]  ref_mem [0:511];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [8:0] a, input logic h, input logic b);
    logic [31:0] v;
    v = {ref_mem[a + 9'd3], ref_mem[a + 9'd2], ref_mem[a + 9'd1], ref_mem[a]};
    if (b)      v = v & 32'h0000_00FF;
    else if (h) v = v & 32'h0000_FFFF;
    return v;
  endfunction

  task automatic model_clear();
    cur = '0; n1 = '0; busy = 0; lg = 1'b0; if_rd_m = '0; dm_rd_m = '0;
  endtask

  task automatic model_step();
    logic dm, w, h, b, we, ok;
    logic [8:0]  a;
    logic [31:0] wd;
    if (cur.acc) begin
      if (cur.we) begin
        ref_mem[cur.a] = cur.wd[7:0];
        if (cur.h || cur.w) ref_mem[cur.a + 9'd1] = cur.wd[15:8];
        if (cur.w) begin
          ref_mem[cur.a + 9'd2] = cur.wd[23:16];
          ref_mem[cur.a + 9'd3] = cur.wd[31:24];
        end
      end else if (cur.who) dm_rd_m = ref_read(cur.a, cur.h, cur.b);
      else                  if_rd_m = ref_read(cur.a, cur.h, cur.b);
    end
    cur = n1;
    n1  = '0;
    if (busy != 0) busy--;
    else if (bus.if_req || bus.dm_req) begin
      dm = bus.dm_req && (!bus.if_req || !lg);
      lg = dm;
      if (dm) begin
        a = bus.dm_address; w = bus.dm_word; h = bus.dm_half; b = bus.dm_single_byte;
        we = bus.dm_write_enable; wd = bus.dm_write_data;
        ok = (int'(w) + int'(h) + int'(b) == 1) && !(w && a[1:0] != 2'b00) && !(h && a[0]);
      end else begin
        a = bus.if_address; w = 1'b1; h = 1'b0; b = 1'b0; we = 1'b0; wd = '0;
        ok = (a[1:0] == 2'b00);
      end
      if (!ok) begin
        cur.ifd = !dm; cur.ife = !dm; cur.dmd = dm; cur.dme = dm;
        busy = 1;
      end else begin
        cur.acc = 1'b1; cur.who = dm; cur.we = we; cur.w = w; cur.h = h; cur.b = b;
        cur.a = a; cur.wd = we ? wd : 32'h0;
        n1.ifd = !dm; n1.dmd = dm;
        busy = 2;
      end
    end
  endtask

  task automatic compare();
    chk("done_err", 64'({bus.if_done, bus.if_error, bus.dm_done, bus.dm_error}),
        64'({cur.ifd, cur.ife, cur.dmd, cur.dme}));
    chk("mem_ctl", 64'({bus.mem_write_enable, bus.mem_word, bus.mem_half, bus.mem_single_byte}),
        64'({cur.we, cur.w, cur.h, cur.b}));
    chk("mem_addr", 64'(bus.mem_address), 64'(cur.a));
    if (!cur.acc || cur.we) chk("mem_wdata", 64'(bus.mem_write_data), 64'(cur.wd));
    if (cur.ifd && !cur.ife) chk("if_rdata", 64'(bus.if_read_data), 64'(if_rd_m));
    if (cur.dmd && !cur.dme) chk("dm_rdata", 64'(bus.dm_read_data), 64'(dm_rd_m));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_clear(); else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic preload_byte(input logic [8:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic preload_word(input logic [8:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) preload_byte(a + 9'(k), v[8*k +: 8]);
  endtask

  task automatic set_dm(input logic we, input logic [2:0] size, input logic [8:0] a,
                        input logic [31:0] wd);
    bus.dm_write_enable = we;
    {bus.dm_word, bus.dm_half, bus.dm_single_byte} = size;
    bus.dm_address = a;
    bus.dm_write_data = wd;
    bus.dm_req = 1'b1;
  endtask

  logic        if_act, dm_act;
  int          if_wait, dm_wait, max_wait;
  logic [31:0] before40;
  logic [8:0]  ra;
  int          r;

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_address = '0;
    bus.dm_req = 1'b0; bus.dm_write_enable = 1'b0; bus.dm_word = 1'b0; bus.dm_half = 1'b0;
    bus.dm_single_byte = 1'b0; bus.dm_address = '0; bus.dm_write_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    model_clear();
    for (int i = 0; i < 512; i++) preload_byte(9'(i), 8'($urandom));
    preload_word(9'h010, 32'h00A0_0093);

    // Reset state
    chk("rst_ctl", 64'({bus.if_done, bus.if_error, bus.dm_done, bus.dm_error, bus.mem_write_enable,
                        bus.mem_word, bus.mem_half, bus.mem_single_byte}), 64'h0);
    chk("rst_mem_bus", 64'({bus.mem_address, bus.mem_write_data}), 64'h0);
    chk("rst_rdata", {bus.if_read_data, bus.dm_read_data}, 64'h0);

    // Fetch word at 0x010
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_address = 9'h010;
    tick();
    chk("if_c1_ctl", 64'({bus.mem_write_enable, bus.mem_word}), 64'b01);
    chk("if_c1_addr", 64'(bus.mem_address), 64'h010);
    tick();
    chk("if_c2_done", 64'({bus.if_done, bus.if_error}), 64'b10);
    chk("if_c2_data", 64'(bus.if_read_data), 64'h00A0_0093);
    bus.if_req = 1'b0;

    // sw 0x100 then lb 0x101
    set_dm(1'b1, 3'b100, 9'h100, 32'hDEAD_BEEF);
    tick();
    chk("sw_c0_we", 64'(bus.mem_write_enable), 64'h0);
    tick();
    chk("sw_c1_we", 64'(bus.mem_write_enable), 64'h1);
    tick();
    chk("sw_c2_we", 64'(bus.mem_write_enable), 64'h0);
    chk("sw_c2_done", 64'({bus.dm_done, bus.dm_error}), 64'b10);
    set_dm(1'b0, 3'b001, 9'h101, 32'h0);
    run(3);
    chk("lb_done", 64'({bus.dm_done, bus.dm_error}), 64'b10);
    chk("lb_data", 64'(bus.dm_read_data), 64'h0000_00BE);
    bus.dm_req = 1'b0;
    tick();

    // Both held from reset: DM, IF, DM, IF, then DM's pending request
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_address = 9'h010;
    set_dm(1'b0, 3'b100, 9'h100, 32'h0);
    tick();
    reset = 1'b0;
    run(2);
    chk("rr0_dm", 64'({bus.dm_done, bus.if_done}), 64'b10);
    chk("rr0_data", 64'(bus.dm_read_data), 64'hDEAD_BEEF);
    run(3);
    chk("rr1_if", 64'({bus.dm_done, bus.if_done}), 64'b01);
    chk("rr1_data", 64'(bus.if_read_data), 64'h00A0_0093);
    run(3);
    chk("rr2_dm", 64'({bus.dm_done, bus.if_done}), 64'b10);
    run(3);
    chk("rr3_if", 64'({bus.dm_done, bus.if_done}), 64'b01);
    bus.if_req = 1'b0;
    run(3);
    chk("rr4_dm", 64'({bus.dm_done, bus.if_done}), 64'b10);
    bus.dm_req = 1'b0;
    tick();

    // Misaligned lh, misaligned fetch, bad size
    set_dm(1'b1, 3'b010, 9'h103, 32'hFFFF_FFFF);
    tick();
    chk("lh_err", 64'({bus.dm_done, bus.dm_error, bus.mem_write_enable}), 64'b110);
    bus.dm_req = 1'b0;
    tick();
    chk("lh_mem", 64'({mem[9'h103], mem[9'h102]}), 64'hDEAD);
    bus.if_req = 1'b1; bus.if_address = 9'h012;
    tick();
    chk("if_misalign", 64'({bus.if_done, bus.if_error, bus.mem_word}), 64'b110);
    bus.if_req = 1'b0;
    tick();
    set_dm(1'b0, 3'b110, 9'h100, 32'h0);
    tick();
    chk("bad_size", 64'({bus.dm_done, bus.dm_error, bus.mem_word, bus.mem_half}), 64'b1100);
    bus.dm_req = 1'b0;
    tick();

    // Reset in the middle of a store's memory cycle
    before40 = {mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]};
    set_dm(1'b1, 3'b100, 9'h040, 32'h1234_5678);
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("arst_ctl", 64'({bus.mem_write_enable, bus.mem_word, bus.dm_done, bus.if_done}), 64'h0);
    chk("arst_bus", 64'({bus.mem_address, bus.mem_write_data}), 64'h0);
    chk("arst_rdata", {bus.if_read_data, bus.dm_read_data}, 64'h0);
    @(negedge clk);
    compare();
    bus.dm_req = 1'b0;
    tick();
    chk("arst_mem", 64'({mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]}), 64'(before40));
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_address = 9'h010;
    run(2);
    chk("post_rst_if", 64'({bus.if_done, bus.if_error}), 64'b10);
    chk("post_rst_data", 64'(bus.if_read_data), 64'h00A0_0093);
    bus.if_req = 1'b0;
    tick();

    // Random traffic from both requesters
    if_act = 1'b0; dm_act = 1'b0; if_wait = 0; dm_wait = 0; max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_act && cur.ifd) if_act = 1'b0;
      if (dm_act && cur.dmd) dm_act = 1'b0;
      if (!if_act && $urandom_range(0, 2) == 0) begin
        ra = 9'($urandom);
        if ($urandom_range(0, 5) != 0) ra[1:0] = 2'b00;
        bus.if_address = ra;
        if_act = 1'b1;
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        {bus.dm_word, bus.dm_half, bus.dm_single_byte} =
          (r < 3) ? 3'b100 : (r < 6) ? 3'b010 : (r < 9) ? 3'b001 : 3'($urandom);
        ra = 9'($urandom);
        if ($urandom_range(0, 5) != 0) begin
          if (bus.dm_word) ra[1:0] = 2'b00;
          if (bus.dm_half) ra[0] = 1'b0;
        end
        bus.dm_address = ra;
        bus.dm_write_enable = 1'($urandom_range(0, 1));
        bus.dm_write_data = $urandom;
        dm_act = 1'b1;
      end
      bus.if_req = if_act;
      bus.dm_req = dm_act;
      tick();
      if (if_act && !bus.if_done) if_wait++; else if_wait = 0;
      if (dm_act && !bus.dm_done) dm_wait++; else dm_wait = 0;
      if (if_wait > max_wait) max_wait = if_wait;
      if (dm_wait > max_wait) max_wait = dm_wait;
    end
    chk("no_starvation", 64'(max_wait > 6), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
